z_rx_stage: RTL and testbench



---
 rtl/zrx_pkg.sv | 42 ++++
 rtl/z_stable_filter.sv | 87 ++++++++
 rtl/z_rx_stage.sv | 99 +++++++++
 tb/tb_z_rx_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zrx_pkg.sv
// Shared types and helpers for the z bus receive path: sample type, filter states, ReLU and 7-seg decode.
// No logic of its own; latency and backpressure live in the modules that import it.
package zrx_pkg;

  localparam int ZRX_DATA_W = 4;

  typedef logic signed [ZRX_DATA_W-1:0] z_t;

  typedef enum logic {
    SETTLE = 1'b0,
    WAIT   = 1'b1
  } filt_state_t;

  function automatic z_t relu(input z_t z);
    return z[ZRX_DATA_W-1] ? z_t'(0) : z;
  endfunction

  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/z_stable_filter.sv
// Synchronises the strobe-less z bus and emits a one-cycle accept pulse once a value has been stable for STABLE_CYCLES samples.
// Latency SYNC_STAGES+STABLE_CYCLES edges to the pulse; no backpressure, the pulse is never held off.
module z_stable_filter
  import zrx_pkg::*;
#(
  parameter int DATA_W        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_z_async,
  input  logic [DATA_W-1:0] i_held_z,
  output logic              o_acc_vld,
  output logic [DATA_W-1:0] o_acc_dat,
  output logic              o_busy
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync;
  logic [DATA_W-1:0]                  w_z_s;

  filt_state_t       r_state;
  filt_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_cand;
  logic [DATA_W-1:0] w_cand_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              r_have_first;
  logic              r_busy;
  logic              w_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_z_async};
    end
  end

  assign w_z_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= SETTLE;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_have_first <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == SETTLE);
      if (w_acc) begin
        r_have_first <= 1'b1;
      end
    end
  end

  // A settled value equal to the one already held is a glitch that came back: no new sample.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_acc       = 1'b0;
    if (w_z_s != r_cand) begin
      w_cand_nxt  = w_z_s;
      w_cnt_nxt   = '0;
      w_state_nxt = SETTLE;
    end else if (r_state == SETTLE) begin
      if (r_cnt != CNT_LAST) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        w_state_nxt = WAIT;
        w_acc       = !r_have_first || (r_cand != i_held_z);
      end
    end
  end

  assign o_acc_vld = w_acc;
  assign o_acc_dat = r_cand;
  assign o_busy    = r_busy;

endmodule

// File: rtl/z_rx_stage.sv
// FPGA2 z bus receive stage: filtered sample + ReLU held on valid/ready, sticky overrun, wrapping sample counter.
// Latency SYNC_STAGES+STABLE_CYCLES+1 edges bus->valid; a new sample overwrites an unconsumed one and sets overrun. ZRX_HEX_EN adds o_hex0.
module z_rx_stage
  import zrx_pkg::*;
#(
  parameter int DATA_W        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_gpio_z_async,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_z,
  output logic [DATA_W-1:0] o_out_act,
  output logic              o_overrun,
  output logic [CNT_W-1:0]  o_sample_cnt,
`ifdef ZRX_HEX_EN
  output logic [6:0]        o_hex0,
`endif
  output logic              o_busy
);

  logic              w_acc_vld;
  logic [DATA_W-1:0] w_acc_dat;
  logic [DATA_W-1:0] w_act;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_z;
  logic [DATA_W-1:0] r_out_act;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_sample_cnt;

  z_stable_filter #(
    .DATA_W        (DATA_W),
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_z_async (i_gpio_z_async),
    .i_held_z  (r_out_z),
    .o_acc_vld (w_acc_vld),
    .o_acc_dat (w_acc_dat),
    .o_busy    (o_busy)
  );

  generate
    if (DATA_W == ZRX_DATA_W) begin : g_pkg_relu
      assign w_act = relu(z_t'(w_acc_dat));
    end else begin : g_wide_relu
      assign w_act = w_acc_dat[DATA_W-1] ? '0 : w_acc_dat;
    end
  endgenerate

  // An accept always wins over the transfer; it only counts as overrun if nobody took the old sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_z      <= '0;
      r_out_act    <= '0;
      r_overrun    <= 1'b0;
      r_sample_cnt <= '0;
    end else if (w_acc_vld) begin
      r_out_valid  <= 1'b1;
      r_out_z      <= w_acc_dat;
      r_out_act    <= w_act;
      r_sample_cnt <= r_sample_cnt + 1'b1;
      if (r_out_valid && !i_out_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef ZRX_HEX_EN
  logic [6:0] r_hex0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hex0 <= 7'b1000000;
    end else if (w_acc_vld) begin
      r_hex0 <= hex7(4'(w_act));
    end
  end

  assign o_hex0 = r_hex0;
`endif

  assign o_out_valid  = r_out_valid;
  assign o_out_z      = r_out_z;
  assign o_out_act    = r_out_act;
  assign o_overrun    = r_overrun;
  assign o_sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_z_rx_stage.sv
// Bench for z_rx_stage: directed scenarios plus random bus/ready traffic against a run-length reference model.
module tb_z_rx_stage;

  localparam int DW = 4;
  localparam int SS = 2;
  localparam int ST = 16;
  localparam int CW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] bus   = '0;

  logic          vld;
  logic [DW-1:0] oz;
  logic [DW-1:0] oact;
  logic          ovr;
  logic [CW-1:0] scnt;
  logic          busy;
`ifdef ZRX_HEX_EN
  logic [6:0]    hex0;
`endif

  z_rx_stage #(
    .DATA_W        (DW),
    .SYNC_STAGES   (SS),
    .STABLE_CYCLES (ST),
    .CNT_W         (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_gpio_z_async (bus),
    .i_out_ready    (ready),
    .o_out_valid    (vld),
    .o_out_z        (oz),
    .o_out_act      (oact),
    .o_overrun      (ovr),
    .o_sample_cnt   (scnt),
`ifdef ZRX_HEX_EN
    .o_hex0         (hex0),
`endif
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: synchronised sample = bus value SS edges ago; a value is accepted on the
  // edge where it has been seen for ST+1 consecutive edges, unless it equals the held sample.
  int q_bus[$];
  int m_cand, m_run, m_have;
  int m_vld, m_z, m_act, m_ovr, m_cnt, m_busy;

  function automatic int relu_ref(input int v);
    int s;
    s = (v >= 8) ? v - 16 : v;
    return (s < 0) ? 0 : s;
  endfunction

  task automatic model_reset();
    q_bus = {};
    for (int i = 0; i < SS; i++) q_bus.push_back(0);
    m_cand = 0; m_run = 1; m_have = 0;
    m_vld = 0; m_z = 0; m_act = 0; m_ovr = 0; m_cnt = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    int zs;
    bit acc;
    q_bus.push_back(int'(bus));
    zs = q_bus.pop_front();
    if (zs == m_cand) m_run++;
    else begin
      m_cand = zs;
      m_run  = 1;
    end
    acc = (m_run == ST + 1) && (m_have == 0 || zs != m_z);
    if (acc) begin
      if (m_vld != 0 && !ready) m_ovr = 1;
      m_vld  = 1;
      m_z    = zs;
      m_act  = relu_ref(zs);
      m_cnt  = (m_cnt + 1) % 256;
      m_have = 1;
    end else if (m_vld != 0 && ready) begin
      m_vld = 0;
    end
    m_busy = (m_run <= ST) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("out_valid", vld, m_vld);
    check("out_z", oz, m_z);
    check("out_act", oact, m_act);
    check("overrun", ovr, m_ovr);
    check("sample_cnt", scnt, m_cnt);
    check("busy", busy, m_busy);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic hold(input int v, input int n);
    bus = v[DW-1:0];
    repeat (n) step();
  endtask

  task automatic do_reset(input int v);
    #2 rst_n = 1'b0;
    bus = v[DW-1:0];
    #1;
    model_reset();
    compare_all();
    check("rst_out_valid", vld, 0);
    check("rst_sample_cnt", scnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic measure_lat(input string tag);
    int n = 0;
    while (n < 40) begin
      step();
      n++;
      if (vld === 1'b1) break;
    end
    check(tag, n, 19);
  endtask

  initial begin
    int nv;
    int v;
    int len;

    model_reset();
    do_reset(3);

    // First sample after reset.
    measure_lat("lat_first");
    check("first_z", oz, 3);
    check("first_act", oact, 3);
    check("first_cnt", scnt, 1);
    check("first_busy", busy, 0);

    // Negative value, consumed immediately.
    ready = 1'b1;
    bus   = 4'hD;
    nv    = 0;
    repeat (30) begin
      step();
      if (vld === 1'b1) nv++;
    end
    check("neg_pulses", nv, 1);
    check("neg_z", oz, 4'hD);
    check("neg_act", oact, 0);
    check("neg_cnt", scnt, 2);

    // Glitch away from a held 3 and back produces nothing.
    hold(3, 25);
    check("held3_cnt", scnt, 3);
    hold(5, 10);
    check("glitch_busy", busy, 1);
    bus = 4'd3;
    nv  = 0;
    repeat (30) begin
      step();
      if (vld === 1'b1) nv++;
    end
    check("glitch_no_valid", nv, 0);
    check("glitch_cnt", scnt, 3);

    // Overwrite while downstream stalls.
    ready = 1'b0;
    hold(2, 20);
    hold(6, 20);
    check("ovr_z", oz, 6);
    check("ovr_flag", ovr, 1);
    check("ovr_cnt", scnt, 5);
    ready = 1'b1;
    step();
    check("ovr_drain", vld, 0);

    // Bus toggling every cycle never settles.
    for (int i = 0; i < 40; i++) begin
      bus = (i % 2 == 1) ? 4'd9 : 4'd10;
      step();
    end
    check("toggle_busy", busy, 1);
    check("toggle_cnt", scnt, 5);

    // Reset in the middle of settling, then restart from scratch.
    hold(7, 11);
    check("mid_busy", busy, 1);
    do_reset(7);
    check("mid_rst_z", oz, 0);
    check("mid_rst_ovr", ovr, 0);
    check("mid_rst_busy", busy, 0);
    measure_lat("lat_restart");
    check("restart_z", oz, 7);

    // Random bus values, hold lengths and ready pattern.
    for (int p = 0; p < 150; p++) begin
      v   = int'($urandom_range(0, 15));
      len = int'($urandom_range(1, 24));
      bus = v[DW-1:0];
      for (int c = 0; c < len; c++) begin
        ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    // Counter wrap over 256 alternating accepts.
    do_reset(1);
    ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      hold((k % 2 == 1) ? 2 : 1, 20);
    end
    check("wrap_cnt", scnt, 0);
    check("wrap_z", oz, 2);
    check("wrap_ovr", ovr, 0);
`ifdef ZRX_HEX_EN
    check("hex0_two", hex0, 7'b0100100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
